fma_pipe: RTL
=============

Name: fma_pipe

Overview:
- Pipelined single-precision multiply-add unit covering all four fused-family ops (fmadd, fmsub, fnmsub, fnmadd), selected per operation.
- Sits between the issue logic and the FP register writeback.
- Built from the team's combinational fmul and fsub blocks, with valid/ready handshakes on both ends, a tag passthrough, stall and flush.
- Not fused in the IEEE sense: the product is rounded by fmul, then the sum is rounded by fsub (double rounding is accepted).

Parameters:
- TAG_W, 4: width of the opaque tag carried alongside each operation.
- W, 32: operand width; only 32 (binary32) is supported, and any other value must fail elaboration.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operation offered.
- in_ready  output  1  unit can accept this cycle.
- in_op  input  2  00 fmadd a*b+c; 01 fmsub a*b-c; 10 fnmsub -(a*b)+c; 11 fnmadd -(a*b)-c.
- in_a  input  W  multiplicand.
- in_b  input  W  multiplier.
- in_c  input  W  addend.
- in_tag  input  TAG_W  tag, returned unchanged with the result.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- out_res  output  W  result.
- out_tag  output  TAG_W  tag of the result.
- flush  input  1  synchronous kill of all in-flight operations.
- busy  output  1  high when any stage holds a valid operation.

Behaviour:
- Reset: asynchronous, active-high. Clears s1_valid, s2_valid and all data/tag registers to 0. While rst is high: out_valid=0, out_res=0, out_tag=0, busy=0, in_ready=0. in_ready is 1 from the first cycle after rst deasserts.
- Reset mid-operation: in-flight operations are discarded. No partial result is ever presented.
- Transfer rules:
  - Input transfer occurs when in_valid&&in_ready at a rising edge.
  - Output transfer occurs when out_valid&&out_ready at a rising edge.
  - Inputs must be held stable while in_valid&&!in_ready.
  - out_res and out_tag are held stable while out_valid&&!out_ready.
- Stage S1 (multiply):
  - On input transfer, capture p = fmul(in_a,in_b), c, op and tag into S1; set s1_valid.
- Stage S2 (add):
  - When S1 advances, compute p' = {p[31]^op[1], p[30:0]} and x = {c[31]^~op[0], c[30:0]}.
  - Capture fsub(p', x), tag into S2; set s2_valid.
  - Sign flips are raw bit XORs; NaN/Inf/zero handling is whatever fmul/fsub produce.
- Flow control (full-throughput, bubble-collapsing):
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv && !rst.
  - S1 moves into S2 when s1_valid&&s2_adv. S2 drops its valid on output transfer unless it is refilled in the same cycle.
  - S1 loads a new op on input transfer; otherwise s1_valid clears when S1 moves on.
- Latency: 2 cycles. An op accepted at edge N has out_valid high after edge N+1 and transfers at edge N+2 if out_ready=1.
- Throughput: 1 op/cycle sustained while out_ready=1. Capacity is 2 ops.
- Full: both stages valid and out_ready=0 gives in_ready=0. Nothing is overwritten or lost.
- Simultaneous events:
  - Output transfer, S1-to-S2 move and input transfer can all happen in one edge; all three take effect.
  - A bubble in S2 is filled even when out_ready=0.
- flush:
  - At the edge: s1_valid=0, s2_valid=0.
  - An input presented in the flush cycle is not accepted; in_ready=0 during flush.
  - An output presented in the flush cycle is not counted as transferred even if out_ready=1.
  - Data registers are don't-care after flush.
- busy = s1_valid || s2_valid.
- No exception flags are produced. Rounding mode is fixed to whatever fmul/fsub implement.

Test Plan:
- Op coverage: a=0x40000000 (2.0), b=0x40400000 (3.0), c=0x3F800000 (1.0), ops 00/01/10/11 back-to-back, out_ready=1 -> results 0x40E00000, 0x40A00000, 0xC0A00000, 0xC0E00000 on 4 consecutive cycles, first one 2 cycles after first accept, tags in order.
- Backpressure: issue 3 ops with tags 1,2,3 and hold out_ready=0 -> in_ready drops after 2 accepts, tag 1 result held stable. Raise out_ready -> tags 1,2,3 emerge in order, none lost or duplicated.
- Bubble collapse: accept 1 op, out_ready=0 for 3 cycles, then offer a second op -> second op is accepted on the first cycle S1 is free; busy=1 throughout.
- Flush: 2 ops in flight, assert flush 1 cycle -> out_valid=0 and busy=0 the next cycle. A later op (tag 7, 2.0*3.0+1.0) returns 0x40E00000 with tag 7.
- Reset mid-operation: 2 ops in flight, pulse rst asynchronously between edges -> out_valid, busy and in_ready are 0 immediately. After release, in_ready=1 and no stale result appears.
- Special values: a=0x7F800000 (+Inf), b=0x00000000, op 00, c=1.0 -> out_res equals fsub(fmul(+Inf,0) with sign rule, x) reference model output; out_valid timing is unchanged.

Source files
------------

// File: rtl/fma_if.sv
// Handshake bundle between the issue logic, the fma_pipe unit and the FP
// writeback: operand/tag request channel, result channel, flush and busy.
interface fma_if #(
  parameter int W     = 32,
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [W-1:0]     in_a;
  logic [W-1:0]     in_b;
  logic [W-1:0]     in_c;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_res;
  logic [TAG_W-1:0] out_tag;
  logic             flush;
  logic             busy;

  // Issue side: offers operations, consumes results, controls flush.
  modport master (
    output in_valid, in_op, in_a, in_b, in_c, in_tag, out_ready, flush,
    input  in_ready, out_valid, out_res, out_tag, busy
  );

  // Unit side.
  modport slave (
    input  in_valid, in_op, in_a, in_b, in_c, in_tag, out_ready, flush,
    output in_ready, out_valid, out_res, out_tag, busy
  );
endinterface

// File: rtl/fma_pipe.sv
// Two-stage single-precision multiply-add (fmadd/fmsub/fnmsub/fnmadd).
// Stage 1 rounds the product (fmul), stage 2 rounds the sum (fsub), so the
// result is double-rounded rather than fused. Both arithmetic blocks round to
// nearest-even, treat subnormal inputs as zero, flush underflowing results to
// a signed zero and return the canonical quiet NaN 0x7FC00000 for any NaN.
// Flow control collapses bubbles and sustains one operation per cycle.
module fma_pipe #(
  parameter int TAG_W = 4,
  parameter int W     = 32
) (
  input  logic  clk,
  input  logic  rst,
  fma_if.slave  bus
);

  if (W != 32) begin : g_width_check
    $error("fma_pipe: only W=32 (binary32) is supported");
  end

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  // Leading-zero count of a non-zero 27-bit significand.
  function automatic logic [4:0] clz27(input logic [26:0] v);
    logic [4:0] n;
    n = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (v[i]) n = 5'(26 - i);
    end
    return n;
  endfunction

  // binary32 multiply, round to nearest-even.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic               s;
    logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [47:0]        prod;
    logic [23:0]        sig;
    logic               g, st;
    logic [24:0]        rnd;
    logic [22:0]        frac;
    logic signed [9:0]  e;
    s      = a[31] ^ b[31];
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'h0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'h0);
    a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'h0);
    b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'h0);
    a_zero = (a[30:23] == 8'h00);
    b_zero = (b[30:23] == 8'h00);
    if (a_nan || b_nan) return QNAN;
    if (a_inf || b_inf) return (a_zero || b_zero) ? QNAN : {s, 8'hFF, 23'h0};
    if (a_zero || b_zero) return {s, 31'h0};
    prod = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e    = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
    if (prod[47]) begin
      sig = prod[47:24];
      g   = prod[23];
      st  = |prod[22:0];
      e   = e + 10'sd1;
    end else begin
      sig = prod[46:23];
      g   = prod[22];
      st  = |prod[21:0];
    end
    rnd = {1'b0, sig} + {24'h0, g & (st | sig[0])};
    if (rnd[24]) begin
      frac = rnd[23:1];
      e    = e + 10'sd1;
    end else begin
      frac = rnd[22:0];
    end
    if (e >= 10'sd255) return {s, 8'hFF, 23'h0};
    if (e <= 10'sd0) return {s, 31'h0};
    return {s, e[7:0], frac};
  endfunction

  // binary32 add, round to nearest-even; exact cancellation gives +0.
  function automatic logic [31:0] fadd(input logic [31:0] x, input logic [31:0] y);
    logic               x_nan, y_nan, x_inf, y_inf, x_zero, y_zero;
    logic [31:0]        big, sml;
    logic [7:0]         d8;
    logic [4:0]         sh, lz;
    logic [26:0]        mb, ms, msh, m;
    logic [27:0]        sum;
    logic               s, rup;
    logic [24:0]        rnd;
    logic [22:0]        frac;
    logic signed [9:0]  e;
    x_nan  = (x[30:23] == 8'hFF) && (x[22:0] != 23'h0);
    y_nan  = (y[30:23] == 8'hFF) && (y[22:0] != 23'h0);
    x_inf  = (x[30:23] == 8'hFF) && (x[22:0] == 23'h0);
    y_inf  = (y[30:23] == 8'hFF) && (y[22:0] == 23'h0);
    x_zero = (x[30:23] == 8'h00);
    y_zero = (y[30:23] == 8'h00);
    if (x_nan || y_nan) return QNAN;
    if (x_inf && y_inf) return (x[31] != y[31]) ? QNAN : x;
    if (x_inf) return x;
    if (y_inf) return y;
    if (x_zero && y_zero) return {x[31] & y[31], 31'h0};
    if (x_zero) return y;
    if (y_zero) return x;
    if (x[30:0] >= y[30:0]) begin
      big = x;
      sml = y;
    end else begin
      big = y;
      sml = x;
    end
    s   = big[31];
    d8  = big[30:23] - sml[30:23];
    sh  = (d8 > 8'd27) ? 5'd27 : d8[4:0];
    mb  = {1'b1, big[22:0], 3'b000};
    ms  = {1'b1, sml[22:0], 3'b000};
    msh = ms >> sh;
    msh[0] = msh[0] | (|(ms & ((27'd1 << sh) - 27'd1)));
    e   = $signed({2'b00, big[30:23]});
    if (big[31] == sml[31]) begin
      sum = {1'b0, mb} + {1'b0, msh};
      if (sum[27]) begin
        m = {sum[27:2], sum[1] | sum[0]};
        e = e + 10'sd1;
      end else begin
        m = sum[26:0];
      end
    end else begin
      sum = {1'b0, mb} - {1'b0, msh};
      if (sum == 28'h0) return 32'h0;
      lz = clz27(sum[26:0]);
      m  = sum[26:0] << lz;
      e  = e - $signed({5'b00000, lz});
    end
    rup = m[2] & (m[1] | m[0] | m[3]);
    rnd = {1'b0, m[26:3]} + {24'h0, rup};
    if (rnd[24]) begin
      frac = rnd[23:1];
      e    = e + 10'sd1;
    end else begin
      frac = rnd[22:0];
    end
    if (e >= 10'sd255) return {s, 8'hFF, 23'h0};
    if (e <= 10'sd0) return {s, 31'h0};
    return {s, e[7:0], frac};
  endfunction

  function automatic logic [31:0] fsub(input logic [31:0] x, input logic [31:0] y);
    return fadd(x, {~y[31], y[30:0]});
  endfunction

  logic             vld_p1, vld_p2;
  logic [W-1:0]     prod_p1, c_p1, res_p2;
  logic [1:0]       op_p1;
  logic [TAG_W-1:0] tag_p1, tag_p2;
  logic             adv_p1, adv_p2, acc_p0, mov_p1;
  logic [W-1:0]     padd_p1, addend_p1;

  // Advance conditions: a stage may take new data when empty or draining.
  always_comb begin
    adv_p2 = !vld_p2 || bus.out_ready;
    adv_p1 = !vld_p1 || adv_p2;
    acc_p0 = bus.in_valid && bus.in_ready;
    mov_p1 = vld_p1 && adv_p2;
  end

  assign bus.in_ready  = adv_p1 && !rst && !bus.flush;
  assign bus.out_valid = vld_p2;
  assign bus.out_res   = res_p2;
  assign bus.out_tag   = tag_p2;
  assign bus.busy      = vld_p1 || vld_p2;

  // Stage valids: flush kills both stages; S2 refill wins over its drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else if (bus.flush) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      if (acc_p0)      vld_p1 <= 1'b1;
      else if (mov_p1) vld_p1 <= 1'b0;
      if (mov_p1)             vld_p2 <= 1'b1;
      else if (bus.out_ready) vld_p2 <= 1'b0;
    end
  end

  // ---- stage 0 -> 1: rounded product, addend, op and tag ----
  // Capture the multiply result alongside the operands stage 2 still needs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_p1 <= '0;
      c_p1    <= '0;
      op_p1   <= '0;
      tag_p1  <= '0;
    end else if (acc_p0) begin
      prod_p1 <= fmul(bus.in_a, bus.in_b);
      c_p1    <= bus.in_c;
      op_p1   <= bus.in_op;
      tag_p1  <= bus.in_tag;
    end
  end

  // ---- stage 1 -> 2: op-dependent sign flips, then rounded subtract ----
  // op[1] negates the product; op[0] clear turns the subtract into an add.
  always_comb begin
    padd_p1   = {prod_p1[31] ^ op_p1[1], prod_p1[30:0]};
    addend_p1 = {c_p1[31] ^ ~op_p1[0], c_p1[30:0]};
  end

  // Result register only loads when S1 moves, so it holds under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_p2 <= '0;
      tag_p2 <= '0;
    end else if (mov_p1) begin
      res_p2 <= fsub(padd_p1, addend_p1);
      tag_p2 <= tag_p1;
    end
  end

endmodule
